// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3).
// Commits a full result at once so the display never shows partial digits.
module bin_to_bcd_seq #(
    parameter int WIDTH       = 16,
    parameter int DIGITS      = 5,
    parameter int DISP_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      bin_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid,
    output logic                  busy,
    output logic                  done,
    output logic                  range_err
);

    localparam int CW = $clog2(WIDTH + 1);

    // True when DIGITS decimal digits can hold the largest WIDTH-bit value.
    function automatic bit digits_fit();
        logic [127:0] p;
        logic [127:0] m;
        p = 128'd1;
        for (int i = 0; i < DIGITS; i++) begin
            p = p * 128'd10;
        end
        m = (128'd1 << WIDTH) - 128'd1;
        return p > m;
    endfunction

    localparam bit DIGITS_OK = digits_fit();

    if (!DIGITS_OK) begin : g_bad_digits
        $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [WIDTH-1:0]    last_bin;
    logic [WIDTH-1:0]    shift_reg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                first_flag;
    logic                trigger;
    logic                over;

    assign trigger = first_flag | (bin_in != last_bin);

    // Add 3 to every scratch digit >= 5, all evaluated on pre-shift values.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Any nonzero digit beyond what the display can show.
    always_comb begin
        over = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k >= DISP_DIGITS) begin
                over = over | (|scratch[4*k +: 4]);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (trigger) next_state = SHIFT;
            SHIFT:   if (cnt == CW'(WIDTH - 1)) next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath, committed outputs and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bin   <= '0;
            shift_reg  <= '0;
            scratch    <= '0;
            cnt        <= '0;
            first_flag <= 1'b1;
            bcd_out    <= '0;
            valid      <= 1'b0;
            range_err  <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            done <= (state == COMMIT);
            busy <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (trigger) begin
                        last_bin   <= bin_in;
                        shift_reg  <= bin_in;
                        scratch    <= '0;
                        cnt        <= '0;
                        first_flag <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch   <= {adj[4*DIGITS-2:0], shift_reg[WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    cnt       <= cnt + CW'(1);
                end
                COMMIT: begin
                    bcd_out   <= scratch;
                    valid     <= 1'b1;
                    range_err <= over;
                end
                default: ;
            endcase
        end
    end

endmodule
